// File: rtl/nn_pkg.sv
// Shared types, constants and the output activation for the sequenced NN layers.
package nn_pkg;

  localparam int unsigned ACT_W     = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned FRAC_SH   = 6;
  localparam int unsigned OUT_MAX   = 127;
  localparam int unsigned ACC_MAX_W = 48;
  localparam int unsigned SAT_LSB   = FRAC_SH + ACT_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_POST
  } state_e;

  // ReLU, then round-half-up by 2^FRAC_SH, then clamp to 0..OUT_MAX; acc arrives sign-extended.
  function automatic logic [ACT_W-1:0] relu_round_sat(input logic signed [ACC_MAX_W-1:0] acc);
    logic [ACT_W:0] r;
    if (acc[ACC_MAX_W-1]) return '0;
    if (acc[ACC_MAX_W-2:SAT_LSB] != '0) return ACT_W'(OUT_MAX);
    r = (ACT_W+1)'(acc[SAT_LSB:FRAC_SH]) + (ACT_W+1)'(acc[FRAC_SH-1]);
    return (r > (ACT_W+1)'(OUT_MAX)) ? ACT_W'(OUT_MAX) : r[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/nn_layer_seq_if.sv
// Control, memory-port and result-stream signals of nn_layer_seq.
// NN_SEQ_STALL_EN adds the out_ready back-pressure input.
interface nn_layer_seq_if #(
  parameter int unsigned ACT_AW    = 5,
  parameter int unsigned W_AW      = 9,
  parameter int unsigned NUM_NODES = 16
) ();
  import nn_pkg::*;

  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ACT_AW-1:0]        act_addr;
  logic signed [ACT_W-1:0]  act_data;
  logic [W_AW-1:0]          w_addr;
  logic signed [ACT_W-1:0]  w_data;
  logic [IDX_W-1:0]         node_idx;
  logic signed [PROD_W-1:0] bias_data;
  logic                     out_valid;
  logic [IDX_W-1:0]         out_idx;
  logic [ACT_W-1:0]         out_data;
`ifdef NN_SEQ_STALL_EN
  logic                     out_ready;
`endif

  // Engine side
  modport master (
    input  start, act_data, w_data, bias_data,
`ifdef NN_SEQ_STALL_EN
    input  out_ready,
`endif
    output busy, done, act_addr, w_addr, node_idx, out_valid, out_idx, out_data
  );

  // Memory / consumer side
  modport slave (
    output start, act_data, w_data, bias_data,
`ifdef NN_SEQ_STALL_EN
    output out_ready,
`endif
    input  busy, done, act_addr, w_addr, node_idx, out_valid, out_idx, out_data
  );

endinterface

// File: rtl/nn_mac.sv
// Registered signed 8x8 multiply-accumulate with bias load and enable.
module nn_mac
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic                     i_en,
  input  logic signed [PROD_W-1:0] i_bias,
  input  logic signed [ACT_W-1:0]  i_a,
  input  logic signed [ACT_W-1:0]  i_b,
  output logic signed [ACC_W-1:0]  o_acc_nxt_c
);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PROD_W-1:0] w_prod;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

  // Value the accumulator takes at the next edge; the top samples it to register its result.
  always_comb begin
    o_acc_nxt_c = r_acc;
    if (i_load)    o_acc_nxt_c = ACC_W'(i_bias);
    else if (i_en) o_acc_nxt_c = r_acc + ACC_W'(w_prod);
  end

  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else       r_acc <= o_acc_nxt_c;
  end

endmodule

// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC sequenced over all neurons.
// Define NN_SEQ_STALL_EN to let out_ready hold each result in POST.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 30,
  parameter int unsigned NUM_NODES  = 16,
  parameter int unsigned ACC_W      = 23,
  parameter int unsigned ACT_AW     = 5,
  parameter int unsigned W_AW       = 9
) (
  input logic          clk,
  input logic          reset,
  nn_layer_seq_if.master bus
);

  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned K_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  state_e r_state, w_next_state;

  logic [K_W-1:0]          r_k;
  logic [IDX_W-1:0]        r_node_idx;
  logic [ACT_AW-1:0]       r_act_addr;
  logic [W_AW-1:0]         r_w_addr;
  logic [W_AW-1:0]         r_w_base;
  logic                    r_busy;
  logic                    r_out_valid;
  logic [IDX_W-1:0]        r_out_idx;
  logic [ACT_W-1:0]        r_out_data;
`ifndef NN_SEQ_STALL_EN
  logic                    r_done;
`endif

  logic                    w_last_k;
  logic                    w_last_node;
  logic                    w_xfer;
  logic                    w_start_ok;
  logic                    w_mac_load;
  logic                    w_mac_en;
  logic                    w_advance;
  logic                    w_finish;
  logic signed [ACC_W-1:0] w_acc_nxt_c;

  assign w_last_k    = (r_k == K_W'(NUM_INPUTS - 1));
  assign w_last_node = (r_node_idx == IDX_W'(NUM_NODES - 1));

`ifdef NN_SEQ_STALL_EN
  assign w_xfer = r_out_valid & bus.out_ready;
`else
  assign w_xfer = 1'b1;
`endif

  nn_mac #(.ACC_W(ACC_W)) u_mac (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_mac_load),
    .i_en        (w_mac_en),
    .i_bias      (bus.bias_data),
    .i_a         (bus.act_data),
    .i_b         (bus.w_data),
    .o_acc_nxt_c (w_acc_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_mac_load   = 1'b0;
    w_mac_en     = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_start_ok   = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_mac_load   = 1'b1;
        w_next_state = ST_MAC;
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (w_last_k) w_next_state = ST_POST;
      end
      ST_POST: begin
        if (w_xfer) begin
          if (w_last_node) begin
            w_finish     = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_LOAD;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Addresses run one index ahead of the MAC so synchronous read data lines up with k.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k         <= '0;
      r_node_idx  <= '0;
      r_act_addr  <= '0;
      r_w_addr    <= '0;
      r_w_base    <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
`ifndef NN_SEQ_STALL_EN
      r_done      <= 1'b0;
`endif
    end else begin
      if (w_start_ok) begin
        r_busy     <= 1'b1;
        r_node_idx <= '0;
        r_act_addr <= '0;
        r_w_addr   <= '0;
        r_w_base   <= '0;
      end
      if (w_mac_load || w_mac_en) begin
        r_act_addr <= r_act_addr + ACT_AW'(1);
        r_w_addr   <= r_w_addr + W_AW'(1);
      end
      if (w_mac_load) r_k <= '0;
      if (w_mac_en)   r_k <= r_k + K_W'(1);
      if (w_mac_en && w_last_k) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= r_node_idx;
        r_out_data  <= relu_round_sat(ACC_MAX_W'(w_acc_nxt_c));
`ifndef NN_SEQ_STALL_EN
        r_done      <= w_last_node;
`endif
      end
      if (w_advance) begin
        r_out_valid <= 1'b0;
        r_node_idx  <= r_node_idx + IDX_W'(1);
        r_act_addr  <= '0;
        r_w_addr    <= r_w_base + W_AW'(NUM_INPUTS);
        r_w_base    <= r_w_base + W_AW'(NUM_INPUTS);
      end
      if (w_finish) begin
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
`ifndef NN_SEQ_STALL_EN
        r_done      <= 1'b0;
`endif
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.act_addr  = r_act_addr;
  assign bus.w_addr    = r_w_addr;
  assign bus.node_idx  = r_node_idx;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_data  = r_out_data;
`ifdef NN_SEQ_STALL_EN
  // Completion is only known once the consumer accepts the last result.
  assign bus.done      = r_out_valid & bus.out_ready & w_last_node;
`else
  assign bus.done      = r_done;
`endif

endmodule

// File: tb/tb_nn_layer_seq.sv
// Self-checking bench for nn_layer_seq against an arithmetic model of the layer.
// Builds with or without NN_SEQ_STALL_EN.
module tb_nn_layer_seq;
  import nn_pkg::*;

  localparam int unsigned NI     = 4;
  localparam int unsigned NN     = 2;
  localparam int unsigned ACC_W  = 23;
  localparam int unsigned ACT_AW = 5;
  localparam int unsigned W_AW   = 9;
  localparam int          LAT    = NI + 2;

  typedef struct {
    int cyc;
    int idx;
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_layer_seq_if #(.ACT_AW(ACT_AW), .W_AW(W_AW), .NUM_NODES(NN)) bus ();

  nn_layer_seq #(
    .NUM_INPUTS(NI), .NUM_NODES(NN), .ACC_W(ACC_W), .ACT_AW(ACT_AW), .W_AW(W_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [7:0]  act_mem  [2**ACT_AW];
  logic signed [7:0]  w_mem    [2**W_AW];
  logic signed [15:0] bias_mem [NN];

  // Synchronous ROMs with one-cycle read latency; bias is combinational on node_idx
  always @(posedge clk) begin
    bus.act_data <= act_mem[bus.act_addr];
    bus.w_data   <= w_mem[bus.w_addr];
  end
  assign bus.bias_data = bias_mem[bus.node_idx];

  int   cyc_pos = 0;
  always @(posedge clk) cyc_pos <= cyc_pos + 1;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  int   n_valid = 0;
  int   n_done = 0;
  int   done_cyc = -1;
  int   got[NN];

`ifdef NN_SEQ_STALL_EN
  int stall_hold = 0;
  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (stall_hold > 0) begin
      bus.out_ready = 1'b0;
      if (bus.out_valid) stall_hold--;
    end else begin
      bus.out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed dot product plus bias, ReLU, round half up by 64, clamp to 127
  function automatic int model_out(input int acc);
    int r;
    if (acc < 0) return 0;
    if (acc >= 8192) return 127;
    r = (acc + 32) / 64;
    return (r > 127) ? 127 : r;
  endfunction

  function automatic int model_acc(input int n);
    int acc;
    acc = int'(bias_mem[n]);
    for (int k = 0; k < NI; k++) acc += int'(act_mem[k]) * int'(w_mem[n*NI + k]);
    return acc;
  endfunction

  task automatic compare_pop();
    if (q.size() == 0) begin
      chk("valid_unexpected", int'(bus.out_valid), 0);
    end else begin
      chk("out_valid", int'(bus.out_valid), 1);
      chk("out_idx", int'(bus.out_idx), q[0].idx);
      chk("out_data", int'(bus.out_data), q[0].data);
      chk("done_on_last", int'(bus.done), int'(q[0].last));
      got[q[0].idx] = int'(bus.out_data);
      n_valid++;
      if (bus.done) begin
        done_cyc = cyc_pos;
        busy_hi  = cyc_pos;
      end
      void'(q.pop_front());
    end
  endtask

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_idx;

  // Per-cycle compare of the DUT outputs against the expected result stream
  always @(negedge clk) begin : mon
    bit eb;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      eb = (cyc_pos >= busy_lo) && (cyc_pos <= busy_hi);
      chk("busy", int'(bus.busy), int'(eb));
      if (bus.done) n_done++;
`ifdef NN_SEQ_STALL_EN
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data", int'(bus.out_data), int'(prev_data));
        chk("hold_idx", int'(bus.out_idx), int'(prev_idx));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_idx   = bus.out_idx;
      if (bus.out_valid && bus.out_ready) compare_pop();
      else chk("done_idle", int'(bus.done), 0);
`else
      if (q.size() > 0 && q[0].cyc == cyc_pos) begin
        compare_pop();
      end else begin
        chk("valid_idle", int'(bus.out_valid), 0);
        chk("done_idle", int'(bus.done), 0);
      end
`endif
    end
  end

  task automatic fill(input int a, input int w, input int b);
    for (int k = 0; k < NI; k++) act_mem[k] = 8'(a);
    for (int i = 0; i < NN*NI; i++) w_mem[i] = 8'(w);
    for (int n = 0; n < NN; n++) bias_mem[n] = 16'(b);
  endtask

  task automatic start_layer(output int t);
    exp_t e;
    @(posedge clk); #1;
    t = cyc_pos;
    for (int n = 0; n < NN; n++) begin
      e.cyc  = t + (n + 1) * LAT;
      e.idx  = n;
      e.data = model_out(model_acc(n));
      e.last = (n == NN - 1);
      q.push_back(e);
    end
    busy_lo   = t + 1;
`ifdef NN_SEQ_STALL_EN
    busy_hi   = 1 << 30;
`else
    busy_hi   = t + NN * LAT;
`endif
    done_cyc  = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_layer();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL layer_timeout: got %0d results pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_directed(input string name, input int e0, input int e1);
    int t;
    chk({name, "_model0"}, model_out(model_acc(0)), e0);
    chk({name, "_model1"}, model_out(model_acc(1)), e1);
    start_layer(t);
    wait_layer();
    chk({name, "_node0"}, got[0], e0);
    chk({name, "_node1"}, got[1], e1);
  endtask

  initial begin : stim
    int t;
    bus.start = 1'b0;
    reset     = 1'b1;
    fill(0, 0, 0);
    for (int i = 0; i < 2**ACT_AW; i++) act_mem[i] = '0;
    for (int i = 0; i < 2**W_AW; i++) w_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_node_idx", int'(bus.node_idx), 0);
    chk("rst_act_addr", int'(bus.act_addr), 0);
    chk("rst_w_addr", int'(bus.w_addr), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // acc = 4*64*16 = 4096 -> 64 for both nodes, done 12 cycles after start
    fill(64, 16, 0);
    n_valid = 0;
    n_done  = 0;
    start_layer(t);
    wait_layer();
    chk("t1_node0", got[0], 64);
    chk("t1_node1", got[1], 64);
    chk("t1_done_latency", done_cyc - t, NN * LAT);
    chk("t1_valid_count", n_valid, 2);
    chk("t1_done_count", n_done, 1);

    fill(64, -16, 0);
    run_directed("neg", 0, 0);
    fill(127, 127, 0);
    run_directed("sat", 127, 127);
    fill(0, 0, 96);
    bias_mem[1] = 16'sd8191;
    run_directed("round", 2, 127);
    fill(1, 1, 8187);
    bias_mem[1] = -5;
    run_directed("edge", 127, 0);

    // Reset during node 0 MAC aborts the layer with no further results
    fill(64, 16, 0);
    start_layer(t);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    q.delete();
    busy_lo = -1;
    busy_hi = -2;
    reset   = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    n_valid = 0;
    n_done  = 0;
    repeat (2 * NN * LAT) @(posedge clk);
    #1;
    chk("abort_no_valid", n_valid, 0);
    chk("abort_no_done", n_done, 0);

    // A second start while busy is ignored
    n_valid = 0;
    n_done  = 0;
    start_layer(t);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_layer();
    repeat (2 * LAT) @(posedge clk);
    #1;
    chk("busy_start_valids", n_valid, 2);
    chk("busy_start_dones", n_done, 1);

`ifdef NN_SEQ_STALL_EN
    // Five cycles of back-pressure on node 0 delay completion by exactly five cycles
    stall_hold = 5;
    rnd_ready  = 1'b0;
    start_layer(t);
    wait_layer();
    chk("stall_node0", got[0], 64);
    chk("stall_done_latency", done_cyc - t, NN * LAT + 5);
    rnd_ready = 1'b1;
`endif

    // Randomized layers over several value ranges
    for (int it = 0; it < 30; it++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < NI; k++)
        act_mem[k] = (mode == 0) ? 8'($urandom) : 8'($urandom_range(0, 40) - 8);
      for (int i = 0; i < NN*NI; i++)
        w_mem[i] = (mode == 0) ? 8'($urandom) : 8'($urandom_range(0, 40) - 8);
      for (int n = 0; n < NN; n++)
        bias_mem[n] = (mode == 2) ? 16'($urandom) : 16'($urandom_range(0, 12000) - 3000);
      start_layer(t);
      wait_layer();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
- Time-multiplexed fully-connected layer engine: one shared 8x8 signed MAC serves NUM_NODES neurons of NUM_INPUTS inputs each.
- Replaces a bank of parallel per-neuron nodes with one sequenced datapath.
- Fetches activations and weights from external synchronous ROM/RAM ports and applies bias, ReLU, rounding and saturation.
- Emits one 8-bit result per neuron through a valid-qualified output stream.

Parameters:
- NUM_INPUTS, 30, inputs per neuron (>=1)
- NUM_NODES, 16, neurons per layer (>=1)
- ACC_W, 23, accumulator width (>= 16 + clog2(NUM_INPUTS+1))
- ACT_AW, 5, activation address width
- W_AW, 9, weight address width (>= clog2(NUM_NODES*NUM_INPUTS))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins layer evaluation when idle
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, coincident with the last out_valid
- act_addr  out  ACT_AW  activation index k
- act_data  in  8  signed activation, valid 1 cycle after act_addr
- w_addr  out  W_AW  node*NUM_INPUTS + k
- w_data  in  8  signed weight, valid 1 cycle after w_addr
- node_idx  out  clog2(NUM_NODES)  current neuron; bias_data must be combinationally valid for it
- bias_data  in  16  signed bias, same scale as a product
- out_valid  out  1  result strobe
- out_idx  out  clog2(NUM_NODES)  neuron index of out_data
- out_data  out  8  result, 0..127

Behaviour:
- Reset: FSM=IDLE; busy, done, out_valid=0; out_data, out_idx, node_idx, act_addr, w_addr, accumulator=0. Reset mid-layer aborts immediately with no further out_valid.
- States: IDLE, LOAD, MAC, POST.
- IDLE: start=1 -> LOAD, node_idx=0. start while not IDLE is ignored.
- LOAD (1 cycle): acc <= sign-extended bias_data; issue addresses for k=0; -> MAC.
- MAC (NUM_INPUTS cycles, counter k): acc += sext(act_data*w_data), a 16-bit signed product; issue addresses for k+1. Address outputs are don't-care after the last index. After k=NUM_INPUTS-1 -> POST.
- POST (1 cycle, no stall): out_valid=1, out_idx=node_idx, out_data=f(acc).
  - If node_idx==NUM_NODES-1: done=1 -> IDLE.
  - Else: node_idx+1 -> LOAD.
- Per-neuron latency: NUM_INPUTS+2 cycles. Layer: NUM_NODES*(NUM_INPUTS+2) cycles from start to done.
- f(acc), applied in order:
  - acc[ACC_W-1]=1 -> 0.
  - Else acc[ACC_W-2:13]!=0 -> 127.
  - Else r = acc[13:6] + acc[5]; r>127 -> 127, else r.
  - Rounding carry into bit 7 clamps to 127; it never wraps to 128.
- Accumulator never overflows for legal parameters; no wrap handling is required.

Optional Feature:
- Macro: NN_SEQ_STALL_EN.
- Defined: adds input port out_ready (1 bit). POST holds out_valid and out_data stable until out_ready=1. Transfer occurs on out_valid&&out_ready, then FSM advances. done asserts on the transfer cycle of the last neuron.
- Undefined: no out_ready port; POST always lasts exactly 1 cycle.

Decomposition:
- Package nn_pkg holds:
  - FSM state enum
  - constants ACT_W=8, PROD_W=16, FRAC_SH=6, OUT_MAX=127
  - function relu_round_sat(acc) -> 8 bits, shared with other layers
- Sub-module nn_mac: registered signed 8x8 multiply-accumulate with load (bias) and enable. Everything else (FSM, counters, address generation) stays in nn_layer_seq.

Test Plan (NUM_INPUTS=4, NUM_NODES=2 unless noted):
- All act=64, all w=16, bias=0 -> acc=4096, out_data=64 for both nodes. done rises 12 cycles after start and coincides with out_idx=1.
- w=-16, act=64, bias=0 -> acc negative -> out_data=0.
- act=127, w=127 -> acc=64516 -> out_data=127 (saturation).
- act=0, bias=96 -> out_data=2 (rounding). act=0, bias=8191 -> out_data=127 (round-carry clamp, not 128).
- Reset asserted mid-MAC of node 0 -> next cycle busy=0 and no out_valid. A start pulse while busy has no effect: exactly 2 out_valid, 1 done per accepted start.
- NN_SEQ_STALL_EN: out_ready held low 5 cycles in POST -> out_valid and out_data stable throughout. Layer completes 5 cycles later than without the stall.
